// File: rtl/dispatch_ctrl.sv
// Front-end dispatch scheduler: an in-order FIFO between fetch and decode that issues one
// instruction per cycle when ROB/RS/LSQ have room. Optional `DISPATCH_BYPASS_EN` skips the FIFO when it is empty.
module dispatch_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_pc,
  output logic             in_ready,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsq_full,
  input  logic             flush,
  output logic             dec_ena,
  output logic [31:0]      dec_inst,
  output logic [31:0]      dec_pc,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic             push, push_fifo, can_issue, byp;
  entry_t           head_e;

  function automatic logic is_mem(input logic [31:0] i);
    return (i[6:0] == 7'b0000011) || (i[6:0] == 7'b0100011);
  endfunction

  // Resource check shared by the FIFO head and the bypass candidate.
  function automatic logic has_room(input logic [31:0] i, input logic rob_f,
                                    input logic rs_f, input logic lsq_f);
    return !rob_f && (is_mem(i) ? !lsq_f : !rs_f);
  endfunction

  assign head_e    = mem[head];
  assign in_ready  = (count != (PTR_W+1)'(DEPTH));
  assign push      = in_valid && in_ready && !flush;
  assign can_issue = (count != '0) && has_room(head_e.inst, rob_full, rs_full, lsq_full) && !flush;

`ifdef DISPATCH_BYPASS_EN
  assign byp = push && (count == '0) && has_room(in_inst, rob_full, rs_full, lsq_full);
`else
  assign byp = 1'b0;
`endif

  assign push_fifo = push && !byp;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_fifo) mem[tail] <= '{inst: in_inst, pc: in_pc};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      dec_ena  <= 1'b0;
      dec_inst <= NOP;
      dec_pc   <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      dec_ena <= 1'b0;
    end else begin
      if (push_fifo) tail <= tail + 1'b1;
      if (can_issue) head <= head + 1'b1;
      count   <= count + {{PTR_W{1'b0}}, push_fifo} - {{PTR_W{1'b0}}, can_issue};
      dec_ena <= can_issue || byp;
      if (can_issue) begin
        dec_inst <= head_e.inst;
        dec_pc   <= head_e.pc;
      end else if (byp) begin
        dec_inst <= in_inst;
        dec_pc   <= in_pc;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus random traffic against a
// queue-based reference model. Define DISPATCH_BYPASS_EN to check the bypass build.
module tb_dispatch_ctrl;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 0, rob_full = 0, rs_full = 0, lsq_full = 0, flush = 0;
  logic [31:0] in_inst = 0, in_pc = 0;
  logic in_ready, dec_ena;
  logic [31:0] dec_inst, dec_pc;
  logic [PTR_W:0] count;

  int n_cmp = 0, n_err = 0;

  ent_t        mq[$];
  logic        m_ena;
  logic [31:0] m_inst, m_pc;

  dispatch_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .rob_full(rob_full), .rs_full(rs_full), .lsq_full(lsq_full),
    .flush(flush), .dec_ena(dec_ena), .dec_inst(dec_inst), .dec_pc(dec_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ok(input logic [31:0] i, input bit rob, input bit rs, input bit lsq);
    bit mem = (i[6:0] == 7'h03) || (i[6:0] == 7'h23);
    return !rob && (mem ? !lsq : !rs);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ena  = 0;
    m_inst = 32'h13;
    m_pc   = 0;
  endfunction

  // One clock edge of the reference model, from the inputs present at that edge.
  function automatic void model_step(input bit v, input logic [31:0] i, input logic [31:0] p,
                                     input bit rob, input bit rs, input bit lsq, input bit fl);
    ent_t e;
    bit acc;
    m_ena = 0;
    if (fl) begin
      mq.delete();
      return;
    end
    acc = v && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      if (ok(mq[0].inst, rob, rs, lsq)) begin
        e = mq.pop_front();
        m_ena = 1; m_inst = e.inst; m_pc = e.pc;
      end
      if (acc) mq.push_back('{i, p});
    end else if (acc) begin
`ifdef DISPATCH_BYPASS_EN
      if (ok(i, rob, rs, lsq)) begin
        m_ena = 1; m_inst = i; m_pc = p;
      end else mq.push_back('{i, p});
`else
      mq.push_back('{i, p});
`endif
    end
  endfunction

  // Called at a negedge: drive inputs, take one posedge, check at the next negedge.
  task automatic cyc(input bit v, input logic [31:0] i, input logic [31:0] p,
                     input bit rob, input bit rs, input bit lsq, input bit fl);
    in_valid = v; in_inst = i; in_pc = p;
    rob_full = rob; rs_full = rs; lsq_full = lsq; flush = fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    @(posedge clk);
    model_step(v, i, p, rob, rs, lsq, fl);
    @(negedge clk);
    chk("dec_ena", 32'(dec_ena), 32'(m_ena));
    chk("dec_inst", dec_inst, m_inst);
    chk("dec_pc", dec_pc, m_pc);
    chk("count", 32'(count), 32'(mq.size()));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0: r[6:0] = 7'h03;
      1: r[6:0] = 7'h23;
      2: r[6:0] = 7'h33;
      3: r[6:0] = 7'h13;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] pc;
    model_reset();
    #12;
    chk("rst_dec_ena", 32'(dec_ena), 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h13);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset then stream three instructions.
    cyc(1, 32'h00A00093, 0, 0, 0, 0, 0);
`ifdef DISPATCH_BYPASS_EN
    chk("stream_first_lat", 32'(dec_ena), 32'h1);
`else
    chk("stream_first_lat", 32'(dec_ena), 32'h0);
`endif
    cyc(1, 32'h00000013, 4, 0, 0, 0, 0);
    cyc(1, 32'h00208133, 8, 0, 0, 0, 0);
    chk("stream_count_le1", 32'(count <= 1), 32'h1);
    idle(3);

    // MEM head stalled on lsq_full blocks the ALU op behind it.
    cyc(1, 32'h0000A183, 32'h100, 0, 0, 1, 0);
    cyc(1, 32'h00208133, 32'h104, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("class_stall_cnt", 32'(count), 32'h2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("class_lw_issue", dec_pc, 32'h100);
    idle(2);

    // Fill to DEPTH under rob_full, then drain; three rounds wrap the pointers.
    pc = 32'h200;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        cyc(1, rnd_inst(), pc, 1, 0, 0, 0);
        pc += 4;
      end
      chk("full_count", 32'(count), DEPTH);
      chk("full_in_ready", 32'(in_ready), 32'h0);
      cyc(1, 32'h13, 32'hdead, 1, 0, 0, 0);
      idle(DEPTH + 1);
    end

    // Push and pop together at count==3.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h33, pc, 1, 0, 0, 0);
      pc += 4;
    end
    cyc(1, 32'h33, pc, 0, 0, 0, 0);
    pc += 4;
    chk("pushpop_count", 32'(count), 32'h3);
    idle(5);

    // Flush at count==3 with an issue due and a push offered.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h33, pc, 1, 0, 0, 0);
      pc += 4;
    end
    cyc(1, 32'h33, pc, 0, 0, 0, 1);
    chk("flush_ena", 32'(dec_ena), 32'h0);
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_ready", 32'(in_ready), 32'h1);
    idle(2);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      pc += 4;
      cyc($urandom_range(0, 3) != 0, rnd_inst(), pc,
          $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
    end

    // Asynchronous reset mid-stream, between clock edges.
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h33, pc, k == 2 ? 1'b0 : 1'b1, 0, 0, 0);
      pc += 4;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dec_ena", 32'(dec_ena), 32'h0);
    chk("arst_dec_inst", dec_inst, 32'h13);
    chk("arst_count", 32'(count), 32'h0);
    model_reset();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    cyc(1, 32'h00A00093, 32'h400, 0, 0, 0, 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
